// File: rtl/sccb_write_arbiter.sv
`timescale 1ns/1ps
// Two-port SCCB register-write arbiter in front of a byte-level I2C master.
// Define SCCB_ARB_RR_EN for round-robin arbitration; the default build gives port 0 fixed priority.
module sccb_write_arbiter #(
  parameter logic [7:0]  SLAVE_ADDR = 8'h42,
  parameter int unsigned GAP_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic       busy,
  output logic       i2c_start,
  output logic       i2c_stop,
  output logic [7:0] i2c_wr_data,
  input  logic [1:0] i2c_ack,
  input  logic [3:0] i2c_state
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, DATA, STOP, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             win_q, win_d;
  logic             grant_win;
  logic             ack_tick, nack_tick;

  assign ack_tick  = (i2c_ack == 2'b11);
  assign nack_tick = (i2c_ack == 2'b10);

`ifdef SCCB_ARB_RR_EN
  logic last_q, last_d;

  // On contention the port that did not win last time goes first.
  assign grant_win = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign grant_win = ~req0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    win_d       = win_q;
`ifdef SCCB_ARB_RR_EN
    last_d      = last_q;
`endif
    busy        = (state_q != IDLE);
    i2c_start   = 1'b0;
    i2c_stop    = 1'b0;
    i2c_wr_data = 8'h00;
    done0       = 1'b0;
    done1       = 1'b0;
    err0        = 1'b0;
    err1        = 1'b0;

    case (state_q)
      IDLE: begin
        if ((i2c_state == 4'd0) && (req0 || req1)) begin
          win_d   = grant_win;
          addr_d  = grant_win ? addr1 : addr0;
          data_d  = grant_win ? data1 : data0;
`ifdef SCCB_ARB_RR_EN
          last_d  = grant_win;
`endif
          state_d = START;
        end
      end
      START: begin
        i2c_start   = 1'b1;
        i2c_wr_data = SLAVE_ADDR;
        state_d     = ADDR;
      end
      ADDR, DATA, STOP: begin
        if (ack_tick) begin
          case (state_q)
            ADDR: begin
              i2c_wr_data = addr_q;
              state_d     = DATA;
            end
            DATA: begin
              i2c_wr_data = data_q;
              state_d     = STOP;
            end
            default: begin
              i2c_stop = 1'b1;
              done0    = ~win_q;
              done1    = win_q;
              cnt_d    = '0;
              state_d  = GAP;
            end
          endcase
        end else if (nack_tick) begin
          // Any NACK abandons the write: stop the bus and report to the winner.
          i2c_stop = 1'b1;
          err0     = ~win_q;
          err1     = win_q;
          cnt_d    = '0;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sccb_write_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for sccb_write_arbiter: a reactive I2C master model acks bytes,
// stimulus queues expected output events, and a monitor compares every non-zero output cycle.
module tb_sccb_write_arbiter;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, data0 = 8'h00, data1 = 8'h00;
  logic       done0, done1, err0, err1, busy;
  logic       i2c_start, i2c_stop;
  logic [7:0] i2c_wr_data;
  logic [1:0] i2c_ack = 2'b00;
  logic [3:0] i2c_state = 4'd0;

  sccb_write_arbiter #(.SLAVE_ADDR(8'h42), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .busy(busy), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_wr_data(i2c_wr_data), .i2c_ack(i2c_ack), .i2c_state(i2c_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic [7:0] wr;
    logic       d0;
    logic       d1;
    logic       e0;
    logic       e1;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  lat = 0;
  int  nack_byte = 0;

  function automatic ev_t mk(logic s, logic p, logic [7:0] w,
                             logic d0, logic d1, logic e0, logic e1);
    return {s, p, w, d0, d1, e0, e1};
  endfunction

  // Expected output events of one write; nb = byte index (1..3) that gets NACKed, 0 = none.
  task automatic push_txn(input int port, input logic [7:0] a, input logic [7:0] d, input int nb);
    ev_t abort_ev;
    abort_ev = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, port == 0, port == 1);
    exp_q.push_back(mk(1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0));
    if (nb == 1) begin exp_q.push_back(abort_ev); return; end
    exp_q.push_back(mk(1'b0, 1'b0, a, 1'b0, 1'b0, 1'b0, 1'b0));
    if (nb == 2) begin exp_q.push_back(abort_ev); return; end
    exp_q.push_back(mk(1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0));
    if (nb == 3) exp_q.push_back(abort_ev);
    else         exp_q.push_back(mk(1'b0, 1'b1, 8'h00, port == 0, port == 1, 1'b0, 1'b0));
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Monitor: every cycle with any output activity must match the head of the queue.
  ev_t got_ev, exp_ev;
  always @(negedge clk) begin
    got_ev = {i2c_start, i2c_stop, i2c_wr_data, done0, done1, err0, err1};
    if (got_ev != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h required=none", got_ev);
      end else begin
        exp_ev = exp_q.pop_front();
        if (got_ev !== exp_ev) begin
          errors++;
          $display("FAIL event got=%h required=%h", got_ev, exp_ev);
        end
      end
    end
  end

  // I2C master model: after each start, acks (or NACKs) three bytes with 'lat' wait cycles each.
  int m_b, m_w;
  bit m_go;
  initial begin
    forever begin
      @(negedge clk);
      if (i2c_start) begin
        @(posedge clk); #1;
        m_b = 1; m_w = 0; m_go = 1'b1;
        while (m_go) begin
          if (rst) begin
            i2c_ack = 2'b00;
            m_go = 1'b0;
          end else if (m_w < lat) begin
            m_w++;
            @(posedge clk); #1;
          end else begin
            i2c_ack = (m_b == nack_byte) ? 2'b10 : 2'b11;
            @(posedge clk); #1;
            i2c_ack = 2'b00;
            if (m_b == nack_byte || m_b == 3) m_go = 1'b0;
            m_b++;
            m_w = 0;
          end
        end
      end
    end
  end

  task automatic wait_done(output int port, output logic was_err);
    port = -1;
    was_err = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done0 || err0) begin port = 0; was_err = err0; return; end
      if (done1 || err1) begin port = 1; was_err = err1; return; end
    end
    checks++;
    errors++;
    $display("FAIL wait_done timeout got=none required=done_or_err");
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_idle timeout got=busy required=idle");
  endtask

  task automatic wait_wr(input logic [7:0] v);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (i2c_wr_data == v) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_wr timeout got=none required=%h", v);
  endtask

  int   p;
  logic e;
  int   order[4];

  initial begin
`ifdef SCCB_ARB_RR_EN
    order = '{0, 1, 0, 1};
`else
    order = '{0, 0, 0, 0};
`endif
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, i2c_start, i2c_stop, i2c_wr_data, done0, done1, err0, err1}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Single write 12/80, immediate acks, then gap length.
    lat = 0; nack_byte = 0;
    push_txn(0, 8'h12, 8'h80, 0);
    @(posedge clk); #1 addr0 = 8'h12; data0 = 8'h80; req0 = 1'b1;
    wait_done(p, e);
    check("t1_port", p, 0);
    check("t1_err", e, 0);
    @(posedge clk); #1 req0 = 1'b0;
    for (int k = 0; k < GAP; k++) begin
      @(negedge clk);
      check("t1_gap_busy", busy, 1);
    end
    @(negedge clk);
    check("t1_idle_busy", busy, 0);

    // Inputs change after grant; latched values must still go out.
    lat = 2;
    push_txn(0, 8'h12, 8'h80, 0);
    @(posedge clk); #1 addr0 = 8'h12; data0 = 8'h80; req0 = 1'b1;
    wait_wr(8'h42);
    #1 addr0 = 8'hFF; data0 = 8'hEE;
    wait_done(p, e);
    check("t2_port", p, 0);
    check("t2_err", e, 0);
    @(posedge clk); #1 req0 = 1'b0;
    wait_idle();

    // Master busy blocks the grant.
    lat = 0;
    @(posedge clk); #1 i2c_state = 4'd3; addr0 = 8'h5A; data0 = 8'hA5; req0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_busy", busy, 0);
      check("t3_start", i2c_start, 0);
    end
    push_txn(0, 8'h5A, 8'hA5, 0);
    #1 i2c_state = 4'd0;
    wait_done(p, e);
    check("t3_port", p, 0);
    @(posedge clk); #1 req0 = 1'b0;
    wait_idle();

    // Reset in DATA abandons the write; a fresh request then completes.
    lat = 3;
    exp_q.push_back(mk(1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1 addr0 = 8'h34; data0 = 8'h56; req0 = 1'b1;
    wait_wr(8'h34);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("t4_rst_outputs", {busy, i2c_start, i2c_stop, i2c_wr_data, done0, done1, err0, err1}, 32'h0);
    req0 = 1'b0;
    @(negedge clk);
    check("t4_rst_hold", {busy, i2c_start, i2c_stop, i2c_wr_data, done0, done1, err0, err1}, 32'h0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_idle", busy, 0);
    lat = 0;
    push_txn(0, 8'h34, 8'h56, 0);
    #1 req0 = 1'b1;
    wait_done(p, e);
    check("t4_port", p, 0);
    check("t4_err", e, 0);
    @(posedge clk); #1 req0 = 1'b0;
    wait_idle();

    // NACK on the slave byte for port 1.
    lat = 1; nack_byte = 1;
    push_txn(1, 8'h55, 8'h10, 1);
    @(posedge clk); #1 addr1 = 8'h55; data1 = 8'h10; req1 = 1'b1;
    wait_done(p, e);
    check("t5_port", p, 1);
    check("t5_err", e, 1);
    @(posedge clk); #1 req1 = 1'b0;
    wait_idle();
    nack_byte = 0;

    // Contention: both ports held for four transactions.
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (order[i] == 0) push_txn(0, 8'hA0, 8'h01, 0);
      else               push_txn(1, 8'hB1, 8'h02, 0);
    end
    @(posedge clk); #1 addr0 = 8'hA0; data0 = 8'h01; addr1 = 8'hB1; data1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(p, e);
      check("t6_grant", p, order[i]);
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
